iter_shifter: RTL
=================

Name: iter_shifter

Overview:
- Multi-cycle shift unit for the MIPS shift instructions: sll, srl, sra, plus their variable forms sllv, srlv and srav.
- The right-shift direction is the main addition: both logical and arithmetic right shifts are supported, with left shift included for completeness.
- Sits beside the ALU and is driven by the control unit through a valid/ready handshake on the operand side and on the result side.
- Shifts STEP bit positions per clock, so the datapath contains no full 32-bit barrel shifter.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STEP, 1, bit positions shifted per RUN cycle. Legal values are 1, 2, 4 and 8.
- SHW, 5, shift-amount width. Must satisfy 2**SHW == WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: a new operation is presented on a, shamt and op.
- in_ready, output, 1: unit can accept an operation. High only in IDLE.
- a, input, WIDTH: operand (rt).
- shamt, input, SHW: shift amount, either the instruction field or rs[4:0].
- op, input, 2: 00 = sll, 01 = srl, 11 = sra, 10 = rotr (see Optional Feature).
- out_valid, output, 1: y holds a finished result.
- out_ready, input, 1: consumer accepts y.
- y, output, WIDTH: result.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - y, shift register, remaining-count and op registers all = 0.
  - Reset mid-operation aborts the operation; no result is produced.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid, capture a into the shift register, and capture shamt as the remaining count and op.
    - If shamt == 0, go to DONE. Otherwise go to RUN.
  - RUN, each cycle:
    - k = min(STEP, remaining).
    - sll: reg <= reg << k, zero fill.
    - srl: reg <= reg >> k, zero fill.
    - sra: reg <= reg >> k, filled with the captured reg[WIDTH-1]. Sign is preserved on every step.
    - remaining <= remaining − k.
    - When the new remaining == 0, go to DONE.
  - DONE:
    - out_valid = 1; y = reg.
    - y is held stable while out_valid = 1 and out_ready = 0.
    - On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency, from the in_valid acceptance edge to the out_valid rise: 1 + ceil(shamt/STEP) cycles.
  - shamt = 0 gives 1 cycle (y = a).
  - shamt = 31 with STEP = 1 gives 32 cycles.
- in_valid while not in IDLE: ignored, since in_ready = 0. The upstream holds it.
- Simultaneous handshakes: out_valid and in_valid are never both accepted in the same cycle. A new operation can be accepted at the earliest one cycle after the out handshake, so throughput is one operation per latency + 2 cycles.
- The last partial step uses k = remaining, so no overshoot occurs, e.g. STEP = 4 with shamt = 7 gives steps of 4 then 3.
- All arithmetic is WIDTH bits. shamt is unsigned. Bits shifted out are discarded.

Optional Feature:
- Macro: ITER_SHIFTER_ROTR_EN.
- Defined: op = 10 performs a rotate right (MIPS32r2 rotr/rotrv), reg <= {reg[k-1:0], reg[WIDTH-1:k]} per step, with the same latency as the other ops.
- Undefined: op = 10 is decoded as srl, and no rotate logic is synthesized.

Test Plan:
- Reset and idle: rst_n low for 3 cycles, released, then idle. in_ready = 1, out_valid = 0, y = 0, busy = 0.
- srl: a = 0xF000_0000, shamt = 4, op = 01, STEP = 1. out_valid rises 5 cycles after acceptance with y = 0x0F00_0000. Hold out_ready low for 3 cycles: y stays stable.
- sra: a = 0x8000_0000, shamt = 31, op = 11, STEP = 1. y = 0xFFFF_FFFF after 32 cycles. Repeating with STEP = 4 gives the same y after 9 cycles.
- sll and the zero case: a = 0x0000_0003, shamt = 2, op = 00 gives y = 0x0000_000C. shamt = 0 gives y = a after 1 cycle.
- Mid-operation events: in_valid pulsed during RUN is ignored and the current result is unchanged. Asserting rst_n low mid-RUN forces IDLE with out_valid = 0 and no stale result afterwards.
- rotr (with ITER_SHIFTER_ROTR_EN): a = 0x0000_0001, shamt = 1, op = 10 gives y = 0x8000_0000. Without the macro, the same stimulus gives y = 0x0000_0000.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle MIPS shift unit (sll/srl/sra) shifting STEP bits per clock.
// Define ITER_SHIFTER_ROTR_EN to make op=2'b10 a rotate right; otherwise it decodes as srl.
`timescale 1ns/1ps
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE; out_valid only in DONE, so the two never coincide.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [SHW-1:0]   rem_q, rem_d;
   logic [1:0]       op_q, op_d;

   logic [SHW-1:0]   k;
   logic [WIDTH-1:0] shl, shr, sar;
`ifdef ITER_SHIFTER_ROTR_EN
   logic [SHW-1:0]   rot_amt;
   logic [WIDTH-1:0] rot;
`endif

   // The final partial step shifts only the remaining amount, so nothing overshoots.
   always_comb begin
      k   = (rem_q < STEP_W) ? rem_q : STEP_W;
      shl = sh_q << k;
      shr = sh_q >> k;
      sar = $unsigned($signed(sh_q) >>> k);
`ifdef ITER_SHIFTER_ROTR_EN
      rot_amt = ~k + SHW'(1);
      rot     = shr | (sh_q << rot_amt);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         rem_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      rem_d   = rem_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sh_d    = a;
               rem_d   = shamt;
               op_d    = op;
               state_d = (shamt == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            case (op_q)
               2'b00:   sh_d = shl;
               2'b01:   sh_d = shr;
               2'b11:   sh_d = sar;
`ifdef ITER_SHIFTER_ROTR_EN
               default: sh_d = rot;
`else
               default: sh_d = shr;
`endif
            endcase
            rem_d = rem_q - k;
            if (rem_q == k) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The shift register itself is the result, so y is stable for as long as DONE lasts.
   assign y         = sh_q;
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

endmodule
